// File: rtl/egg_timer_ctrl.sv
// Egg timer controller: BCD set/countdown registers driven by a SET/RUN/PAUSE/ALARM FSM.
// The alarm returns to SET on its own after ALARM_TICKS seconds, or at once on start/clear.
module egg_timer_ctrl #(
    parameter int ALARM_TICKS = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [3:0] min2_set,
    output logic [3:0] min1_set,
    output logic [3:0] sec2_set,
    output logic [3:0] sec1_set,
    output logic [3:0] min2_count,
    output logic [3:0] min1_count,
    output logic [3:0] sec2_count,
    output logic [3:0] sec1_count,
    output logic       select,
    output logic [1:0] state,
    output logic       alarm
);

    localparam int TW = $clog2(ALARM_TICKS + 1);

    typedef enum logic [1:0] {
        S_SET   = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_ALARM = 2'b11
    } state_t;

    state_t        state_q, state_nxt;
    logic [TW-1:0] tick_cnt;

    logic          set_nz, at_one, alarm_done;
    logic [3:0]    dm2, dm1, ds2, ds1;

    assign set_nz     = |{min2_set, min1_set, sec2_set, sec1_set};
    assign at_one     = ({min2_count, min1_count, sec2_count, sec1_count} == 16'h0001);
    assign alarm_done = tick_1hz && (tick_cnt == TW'(ALARM_TICKS - 1));

    // One-second BCD borrow chain; seconds tens wrap to 5, never 9.
    always_comb begin
        dm2 = min2_count;
        dm1 = min1_count;
        ds2 = sec2_count;
        ds1 = sec1_count;
        if (sec1_count != 4'd0) begin
            ds1 = sec1_count - 4'd1;
        end else begin
            ds1 = 4'd9;
            if (sec2_count != 4'd0) begin
                ds2 = sec2_count - 4'd1;
            end else begin
                ds2 = 4'd5;
                if (min1_count != 4'd0) begin
                    dm1 = min1_count - 4'd1;
                end else begin
                    dm1 = 4'd9;
                    dm2 = min2_count - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_SET;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_SET: begin
                if (!btn_clear && btn_start && set_nz) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (btn_clear)              state_nxt = S_SET;
                else if (tick_1hz && at_one) state_nxt = S_ALARM;
                else if (btn_start)          state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (btn_clear)      state_nxt = S_SET;
                else if (btn_start) state_nxt = S_RUN;
            end
            S_ALARM: begin
                if (btn_start || btn_clear || alarm_done) state_nxt = S_SET;
            end
            default: state_nxt = S_SET;
        endcase
    end

    // Set value: only editable in SET; clear wins over any increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {min2_set, min1_set, sec2_set, sec1_set} <= 16'h0000;
        end else if (state_q == S_SET) begin
            if (btn_clear) begin
                {min2_set, min1_set, sec2_set, sec1_set} <= 16'h0000;
            end else begin
                if (btn_min) begin
                    if (min1_set == 4'd9) begin
                        min1_set <= 4'd0;
                        min2_set <= (min2_set == 4'd9) ? 4'd0 : min2_set + 4'd1;
                    end else begin
                        min1_set <= min1_set + 4'd1;
                    end
                end
                if (btn_sec) begin
                    if (sec1_set == 4'd9) begin
                        sec1_set <= 4'd0;
                        sec2_set <= (sec2_set == 4'd5) ? 4'd0 : sec2_set + 4'd1;
                    end else begin
                        sec1_set <= sec1_set + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {min2_count, min1_count, sec2_count, sec1_count} <= 16'h0000;
        end else begin
            case (state_q)
                S_SET: begin
                    if (!btn_clear && btn_start && set_nz)
                        {min2_count, min1_count, sec2_count, sec1_count} <=
                            {min2_set, min1_set, sec2_set, sec1_set};
                end
                S_RUN: begin
                    if (btn_clear)
                        {min2_count, min1_count, sec2_count, sec1_count} <= 16'h0000;
                    else if (tick_1hz)
                        {min2_count, min1_count, sec2_count, sec1_count} <= {dm2, dm1, ds2, ds1};
                end
                S_PAUSE: begin
                    if (btn_clear)
                        {min2_count, min1_count, sec2_count, sec1_count} <= 16'h0000;
                end
                S_ALARM: begin
                    if (btn_start || btn_clear)
                        {min2_count, min1_count, sec2_count, sec1_count} <= 16'h0000;
                end
                default: ;
            endcase
        end
    end

    // Counter runs only while in ALARM and is held at zero everywhere else,
    // so every entry into ALARM starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tick_cnt <= '0;
        else if (state_q != S_ALARM || state_nxt != S_ALARM)
            tick_cnt <= '0;
        else if (tick_1hz)
            tick_cnt <= tick_cnt + TW'(1);
    end

    assign state  = state_q;
    assign select = (state_q == S_SET);
    assign alarm  = (state_q == S_ALARM);

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl: button/tick sequences with hand-computed BCD results.
module tb_egg_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1hz = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
    logic       btn_min = 1'b0, btn_sec = 1'b0;
    logic [3:0] min2_set, min1_set, sec2_set, sec1_set;
    logic [3:0] min2_count, min1_count, sec2_count, sec1_count;
    logic       select, alarm;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] ST_SET = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10, ST_ALARM = 2'b11;

    egg_timer_ctrl #(.ALARM_TICKS(30)) dut (
        .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz),
        .btn_start(btn_start), .btn_clear(btn_clear), .btn_min(btn_min), .btn_sec(btn_sec),
        .min2_set(min2_set), .min1_set(min1_set), .sec2_set(sec2_set), .sec1_set(sec1_set),
        .min2_count(min2_count), .min1_count(min1_count),
        .sec2_count(sec2_count), .sec1_count(sec1_count),
        .select(select), .state(state), .alarm(alarm)
    );

    always #5 clk = ~clk;

    wire [15:0] set_v = {min2_set, min1_set, sec2_set, sec1_set};
    wire [15:0] cnt_v = {min2_count, min1_count, sec2_count, sec1_count};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock with the given pulses held across the rising edge; returns #1 after it.
    task automatic step(input logic t, input logic st, input logic cl, input logic mn, input logic sc);
        @(negedge clk);
        tick_1hz = t; btn_start = st; btn_clear = cl; btn_min = mn; btn_sec = sc;
        @(posedge clk);
        #1;
        tick_1hz = 0; btn_start = 0; btn_clear = 0; btn_min = 0; btn_sec = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        #23;
        chk("rst_state", 32'(state), 32'(ST_SET));
        chk("rst_set", 32'(set_v), 32'h0000);
        chk("rst_cnt", 32'(cnt_v), 32'h0000);
        chk("rst_select", 32'(select), 32'd1);
        chk("rst_alarm", 32'(alarm), 32'd0);
        reset_n = 1'b1;

        // 2x min, 61x sec -> 02:01 (seconds wrap 59->00 without carry)
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 61; i++) step(0, 0, 0, 0, 1);
        chk("set_0201", 32'(set_v), 32'h0201);
        chk("set_0201_sel", 32'(select), 32'd1);
        chk("set_0201_st", 32'(state), 32'(ST_SET));
        step(0, 0, 0, 1, 1);
        chk("min_sec_same", 32'(set_v), 32'h0302);
        step(0, 1, 1, 1, 1);
        chk("clear_prio_set", 32'(set_v), 32'h0000);
        chk("clear_prio_st", 32'(state), 32'(ST_SET));

        // 01:00 run, minute borrow, run to alarm
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        chk("load_cnt", 32'(cnt_v), 32'h0100);
        chk("load_st", 32'(state), 32'(ST_RUN));
        ticks(1);
        chk("borrow_0059", 32'(cnt_v), 32'h0059);
        chk("run_sel", 32'(select), 32'd0);
        step(0, 0, 0, 1, 1);
        chk("min_ign_run", 32'(set_v), 32'h0100);
        chk("cnt_hold_notick", 32'(cnt_v), 32'h0059);
        ticks(59);
        chk("alarm_cnt", 32'(cnt_v), 32'h0000);
        chk("alarm_st", 32'(state), 32'(ST_ALARM));
        chk("alarm_out", 32'(alarm), 32'd1);
        ticks(29);
        chk("alarm_29", 32'(alarm), 32'd1);
        ticks(1);
        chk("alarm_30_st", 32'(state), 32'(ST_SET));
        chk("alarm_30_al", 32'(alarm), 32'd0);
        chk("alarm_30_sel", 32'(select), 32'd1);
        chk("set_kept", 32'(set_v), 32'h0100);

        // Clear in ALARM; also tick counter restarts on the next ALARM entry
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        ticks(1);
        chk("alarm2_st", 32'(state), 32'(ST_ALARM));
        ticks(5);
        step(0, 0, 1, 0, 0);
        chk("alarm_clr_st", 32'(state), 32'(ST_SET));
        chk("alarm_clr_cnt", 32'(cnt_v), 32'h0000);
        step(0, 1, 0, 0, 0);
        ticks(1);
        ticks(29);
        chk("alarm_cnt_zeroed", 32'(alarm), 32'd1);
        ticks(1);
        chk("alarm3_done", 32'(state), 32'(ST_SET));

        // 00:01 with start+tick together -> ALARM wins, then start leaves ALARM
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("one_start_tick_st", 32'(state), 32'(ST_ALARM));
        chk("one_start_tick_cnt", 32'(cnt_v), 32'h0000);
        step(0, 1, 0, 0, 0);
        chk("alarm_start_st", 32'(state), 32'(ST_SET));

        // 00:05 pause/resume
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        ticks(2);
        chk("run_0003", 32'(cnt_v), 32'h0003);
        step(1, 1, 0, 0, 0);
        chk("pause_cnt", 32'(cnt_v), 32'h0002);
        chk("pause_st", 32'(state), 32'(ST_PAUSE));
        ticks(3);
        chk("pause_frozen", 32'(cnt_v), 32'h0002);
        step(0, 1, 0, 0, 0);
        chk("resume_st", 32'(state), 32'(ST_RUN));
        chk("resume_cnt", 32'(cnt_v), 32'h0002);
        step(1, 1, 1, 0, 0);
        chk("run_clr_st", 32'(state), 32'(ST_SET));
        chk("run_clr_cnt", 32'(cnt_v), 32'h0000);
        chk("run_clr_set", 32'(set_v), 32'h0005);

        // Minutes wrap 99->00, start at 00:00 ignored
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 99; i++) step(0, 0, 0, 1, 0);
        chk("min_99", 32'(set_v), 32'h9900);
        step(0, 0, 0, 1, 0);
        chk("min_wrap", 32'(set_v), 32'h0000);
        step(0, 1, 0, 0, 0);
        chk("start_zero_st", 32'(state), 32'(ST_SET));
        chk("start_zero_cnt", 32'(cnt_v), 32'h0000);

        // Async reset mid-RUN
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        ticks(2);
        chk("pre_rst_cnt", 32'(cnt_v), 32'h0008);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_st", 32'(state), 32'(ST_SET));
        chk("arst_cnt", 32'(cnt_v), 32'h0000);
        chk("arst_set", 32'(set_v), 32'h0000);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        ticks(1);
        chk("post_rst_st", 32'(state), 32'(ST_SET));
        chk("post_rst_cnt", 32'(cnt_v), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/egg_timer_ctrl.md
EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

Interface
REQ-001 Parameter: ALARM_TICKS, 30, number of tick_1hz pulses the alarm stays asserted before auto-return to SET.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 tick_1hz  input  1  one-cycle pulse, once per second.
REQ-005 btn_start  input  1  one-cycle start/pause pulse, already debounced.
REQ-006 btn_clear  input  1  one-cycle clear pulse, already debounced.
REQ-007 btn_min  input  1  one-cycle minutes-increment pulse.
REQ-008 btn_sec  input  1  one-cycle seconds-increment pulse.
REQ-009 min2_set, min1_set, sec2_set, sec1_set  output  4 each  BCD set value (tens/units of minutes, tens/units of seconds).
REQ-010 min2_count, min1_count, sec2_count, sec1_count  output  4 each  BCD countdown value.
REQ-011 select  output  1  display mux control: 1 = show set value, 0 = show count value.
REQ-012 state  output  2  SET=00, RUN=01, PAUSE=10, ALARM=11.
REQ-013 alarm  output  1  high while in ALARM.

Function
REQ-014 FSM states: SET, RUN, PAUSE, ALARM; all outputs are registered or decoded from state only.
REQ-015 select SHALL be 1 in SET and 0 in RUN, PAUSE and ALARM; alarm SHALL be 1 only in ALARM.
REQ-016 SET, btn_min: minutes set value increments in BCD, 00..99, wraps 99->00; seconds unchanged.
REQ-017 SET, btn_sec: seconds set value increments in BCD, 00..59, wraps 59->00, no carry into minutes.
REQ-018 SET, btn_min and btn_sec in the same cycle: both increments apply.
REQ-019 SET, btn_clear: all set digits -> 0; has priority over btn_start/btn_min/btn_sec in that cycle.
REQ-020 SET, btn_start with set value nonzero: count digits load the set value, state -> RUN on the same edge; set value retained.
REQ-021 SET, btn_start with set value 00:00: ignored, state stays SET.
REQ-022 RUN, tick_1hz: count decrements by one second in BCD; sec1 borrows from sec2, seconds 00 borrows from minutes and becomes 59.
REQ-023 RUN, tick_1hz when count = 00:01: count -> 00:00 and state -> ALARM on the same edge.
REQ-024 RUN, btn_start: state -> PAUSE; if tick_1hz coincides, the decrement applies first; if that decrement reaches 00:00, ALARM takes priority over PAUSE.
REQ-025 RUN or PAUSE, btn_clear: state -> SET, count digits -> 0; clear has priority over start and tick.
REQ-026 PAUSE: count frozen, tick_1hz ignored; btn_start -> RUN, no decrement on that edge.
REQ-027 ALARM: internal tick counter (width ceil(log2(ALARM_TICKS+1))) counts tick_1hz; on reaching ALARM_TICKS, state -> SET.
REQ-028 ALARM, btn_start or btn_clear: state -> SET immediately; count digits -> 0; tick counter -> 0.
REQ-029 Tick counter SHALL be zeroed on every entry to ALARM.
REQ-030 btn_min/btn_sec outside SET: ignored.
REQ-031 BCD digits SHALL never hold values above 9 (tens of seconds never above 5).

Reset
REQ-032 reset_n low: state = SET, all set and count digits = 0, tick counter = 0, select = 1, alarm = 0, applied asynchronously.
REQ-033 Reset asserted mid-RUN or mid-ALARM: same values as REQ-032; no pending button or tick effect survives reset release.

Verification
REQ-034 Reset, 2x btn_min, 61x btn_sec -> set value 02:01, select = 1, state = SET.
REQ-035 Set 01:00, btn_start, 1 tick -> count 00:59, state RUN, select 0; 59 more ticks -> count 00:00, state ALARM, alarm 1.
REQ-036 Set 00:05 running, btn_start coincident with tick at 00:03 -> count 00:02, state PAUSE; 3 ticks -> still 00:02; btn_start -> RUN.
REQ-037 Count 00:01 in RUN, btn_start coincident with tick -> count 00:00, state ALARM (not PAUSE).
REQ-038 ALARM with ALARM_TICKS = 30: 29 ticks -> alarm still 1; 30th tick -> state SET, alarm 0, select 1; separately btn_clear in ALARM -> SET next edge.
REQ-039 Set 99 min via btn_min x100 -> 00; btn_start at 00:00 -> stays SET; reset_n pulsed mid-RUN -> all digits 0, state SET.
